count_checker: RTL and testbench

Monitors the 4-bit down counter's output on every sample, one stage downstream of it. Checks that each new value is exactly the previous value minus one (mod 16) and reports wrap-arounds (0 → 15). Counts both wraps and sequence errors for debug on the lab board. Optionally drives a 7-segment digit with the last sampled count.

---
 rtl/count_checker_pkg.sv | 30 +++
 rtl/count_checker_seg7_decode.sv | 14 +
 rtl/count_checker.sv | 153 +++++++++++++++
 tb/tb_count_checker.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/count_checker_pkg.sv
// count_checker_pkg: shared types and constants for the down-counter checker.
// Holds the FSM state enum, counter widths, error saturation limit and the
// active-low 7-segment patterns (bit 0 = a ... bit 6 = g).
package count_checker_pkg;

  localparam int CNT_W = 4;

  localparam logic [CNT_W-1:0] ERR_MAX = 4'd15;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_e;

  // Active-low patterns for hex digits 0..F.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] seg_of(input logic [CNT_W-1:0] digit);
    return SEG_LUT[digit];
  endfunction

endpackage

// File: rtl/count_checker_seg7_decode.sv
// seg7_decode: combinational 4-bit to active-low 7-segment decoder.
module seg7_decode
  import count_checker_pkg::*;
(
  input  logic [CNT_W-1:0] digit_i,
  output logic [6:0]       seg_o
);

  // Straight table lookup, no blanking here; the caller decides when to blank.
  always_comb begin
    seg_o = seg_of(digit_i);
  end

endmodule

// File: rtl/count_checker.sv
// count_checker: watches a 4-bit down counter one stage downstream, checks
// that each new sample is the previous one minus one (mod 16), and counts
// wrap-arounds (0 -> 15) and sequence errors.
// Optional feature macro: COUNT_CHECKER_HEX_EN drives hex0 with the last
// sampled value; without it hex0 is permanently blank.
//
// state | meaning
// SYNC  | no valid reference yet; next sample becomes the reference
// TRACK | reference valid; every sample is checked against prev - 1
// FAULT | a mismatch was seen; next sample re-seeds the reference unchecked
module count_checker
  import count_checker_pkg::*;
#(
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  count_in,
  input  logic              sample_en,
  input  logic              err_clr,
  output logic              locked,
  output logic              wrap,
  output logic [WRAP_W-1:0] wraps,
  output logic              err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [6:0]        hex0
);

  localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = '0;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  prev_q, prev_d;
  logic              locked_q, locked_d;
  logic              wrap_q, wrap_d;
  logic [WRAP_W-1:0] wraps_q, wraps_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]  expected;
  logic              mismatch;

  assign expected = prev_q - CNT_ONE;

  // Next-state logic: FSM transitions, reference update and wrap counting.
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    wrap_d   = 1'b0;
    wraps_d  = wraps_q;
    mismatch = 1'b0;
    if (sample_en) begin
      case (state_q)
        SYNC, FAULT: begin
          prev_d  = count_in;
          state_d = TRACK;
        end
        TRACK: begin
          prev_d = count_in;
          if (count_in == expected) begin
            if (prev_q == CNT_ZERO) begin
              wrap_d  = 1'b1;
              wraps_d = wraps_q + WRAP_ONE;
            end
          end else begin
            mismatch = 1'b1;
            state_d  = FAULT;
          end
        end
        default: begin
          prev_d  = count_in;
          state_d = SYNC;
        end
      endcase
    end
    locked_d = (state_d == TRACK);
  end

  // Error flag and saturating error count; a mismatch beats a same-cycle clear.
  always_comb begin
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (mismatch) begin
      err_d = 1'b1;
      if (err_clr) begin
        err_cnt_d = CNT_ONE;
      end else if (err_cnt_q != ERR_MAX) begin
        err_cnt_d = err_cnt_q + CNT_ONE;
      end
    end else if (err_clr) begin
      err_d     = 1'b0;
      err_cnt_d = CNT_ZERO;
    end
  end

  // State and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SYNC;
      prev_q    <= CNT_ZERO;
      locked_q  <= 1'b0;
      wrap_q    <= 1'b0;
      wraps_q   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= CNT_ZERO;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      locked_q  <= locked_d;
      wrap_q    <= wrap_d;
      wraps_q   <= wraps_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign locked  = locked_q;
  assign wrap    = wrap_q;
  assign wraps   = wraps_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

`ifdef COUNT_CHECKER_HEX_EN
  logic [6:0] seg_next;
  logic [6:0] hex_q, hex_d;

  // Decode the value that prev will hold after this edge so hex0 lines up
  // with the other registered outputs.
  seg7_decode u_seg7_decode (
    .digit_i (prev_d),
    .seg_o   (seg_next)
  );

  // Blank the digit until a first sample has given us something to show.
  always_comb begin
    hex_d = (state_d == SYNC) ? SEG_BLANK : seg_next;
  end

  // Registered segment output.
  always_ff @(posedge clk) begin
    if (rst) begin
      hex_q <= SEG_BLANK;
    end else begin
      hex_q <= hex_d;
    end
  end

  assign hex0 = hex_q;
`else
  assign hex0 = SEG_BLANK;
`endif

endmodule

// File: tb/tb_count_checker.sv
// tb_count_checker: directed-vector bench for count_checker (WRAP_W = 2 so
// the wrap counter rollover is reachable quickly).
module tb_count_checker;

  logic       clk;
  logic       rst;
  logic [3:0] count_in;
  logic       sample_en;
  logic       err_clr;
  logic       locked;
  logic       wrap;
  logic [1:0] wraps;
  logic       err;
  logic [3:0] err_cnt;
  logic [6:0] hex0;

  int n_tests = 0;
  int n_fail  = 0;
  int wrap_seen;
  int wrap_idx;

  count_checker #(.WRAP_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .count_in  (count_in),
    .sample_en (sample_en),
    .err_clr   (err_clr),
    .locked    (locked),
    .wrap      (wrap),
    .wraps     (wraps),
    .err       (err),
    .err_cnt   (err_cnt),
    .hex0      (hex0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected display for a sampled value; blank when the decoder is absent.
  function automatic int exp_hex(input int v);
`ifdef COUNT_CHECKER_HEX_EN
    case (v)
      0: return 'h40;  1: return 'h79;  2: return 'h24;  3: return 'h30;
      4: return 'h19;  5: return 'h12;  6: return 'h02;  7: return 'h78;
      8: return 'h00;  9: return 'h10; 10: return 'h08; 11: return 'h03;
      12: return 'h46; 13: return 'h21; 14: return 'h06; default: return 'h0E;
    endcase
`else
    return 'h7F;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int v, input logic en);
    count_in  = 4'(v);
    sample_en = en;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " locked"},  locked,  0);
    check({tag, " wrap"},    wrap,    0);
    check({tag, " wraps"},   wraps,   0);
    check({tag, " err"},     err,     0);
    check({tag, " err_cnt"}, err_cnt, 0);
    check({tag, " hex0"},    hex0,    'h7F);
  endtask

  initial begin
    rst       = 1'b1;
    count_in  = 4'd0;
    sample_en = 1'b0;
    err_clr   = 1'b0;
    tick();
    tick();
    check_reset_vals("reset");
    rst = 1'b0;

    // Full descending sequence with one wrap.
    wrap_seen = 0;
    wrap_idx  = -1;
    for (int i = 0; i < 18; i++) begin
      drive((31 - i) % 16, 1'b1);
      if (wrap) begin
        wrap_seen++;
        wrap_idx = i;
      end
      if (i == 0) begin
        check("seq locked first", locked, 1);
        check("seq hex first", hex0, exp_hex(15));
      end
    end
    check("seq wrap pulses", wrap_seen, 1);
    check("seq wrap index", wrap_idx, 16);
    check("seq wraps", wraps, 1);
    check("seq err", err, 0);
    check("seq hex last", hex0, exp_hex(14));

    // Single sequence error and resync.
    do_reset();
    check_reset_vals("rst2");
    drive(9, 1'b1);
    check("e1 locked after 9", locked, 1);
    drive(8, 1'b1);
    check("e1 err after 8", err, 0);
    drive(5, 1'b1);
    check("e1 err after 5", err, 1);
    check("e1 cnt after 5", err_cnt, 1);
    check("e1 locked after 5", locked, 0);
    drive(4, 1'b1);
    check("e1 locked after 4", locked, 1);
    check("e1 cnt after 4", err_cnt, 1);
    drive(3, 1'b1);
    check("e1 cnt after 3", err_cnt, 1);
    check("e1 locked after 3", locked, 1);
    drive(0, 1'b0);
    check("hold locked", locked, 1);
    check("hold cnt", err_cnt, 1);
    check("hold wrap", wrap, 0);
    check("hold hex", hex0, exp_hex(3));

    // Repeated unchanged values: every other sample is a mismatch.
    for (int i = 0; i < 40; i++) begin
      drive(3, 1'b1);
      if (i == 0) check("rep cnt first", err_cnt, 2);
    end
    check("rep cnt sat", err_cnt, 15);
    check("rep err", err, 1);
    check("rep locked", locked, 1);

    // Clear racing a mismatch, then a clear alone.
    err_clr = 1'b1;
    drive(3, 1'b1);
    check("clr+mis err", err, 1);
    check("clr+mis cnt", err_cnt, 1);
    check("clr+mis locked", locked, 0);
    drive(3, 1'b0);
    err_clr = 1'b0;
    check("clr err", err, 0);
    check("clr cnt", err_cnt, 0);

    // Five wraps with a 2-bit wrap counter.
    do_reset();
    wrap_seen = 0;
    for (int i = 0; i < 81; i++) begin
      drive(15 - (i % 16), 1'b1);
      if (wrap) wrap_seen++;
    end
    check("roll pulses", wrap_seen, 5);
    check("roll wraps", wraps, 1);
    check("roll err", err, 0);

    // Reset in the same cycle that would have produced a wrap.
    for (int i = 14; i >= 0; i--) drive(i, 1'b1);
    count_in  = 4'd15;
    sample_en = 1'b1;
    do_reset();
    check_reset_vals("rst wrap");
    drive(0, 1'b0);
    check("post rst idle hex", hex0, 'h7F);
    check("post rst idle locked", locked, 0);
    drive(7, 1'b1);
    check("post rst first err", err, 0);
    check("post rst first locked", locked, 1);
    check("post rst first hex", hex0, exp_hex(7));
    drive(6, 1'b1);
    check("post rst second err", err, 0);

    // Reset while in FAULT.
    drive(2, 1'b1);
    check("fault err", err, 1);
    check("fault locked", locked, 0);
    count_in  = 4'd9;
    sample_en = 1'b1;
    do_reset();
    check_reset_vals("rst fault");
    drive(2, 1'b1);
    check("post fault first err", err, 0);
    check("post fault first locked", locked, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
